// File: rtl/alu_pkg.sv
// Shared ALU opcodes and widths, plus the result-buffer state type used by the arbiter.
package alu_pkg;
  localparam int XLEN    = 32;
  localparam int ALU_OPW = 5;

  localparam logic [ALU_OPW-1:0] ALU_ADD   = 5'b00000;
  localparam logic [ALU_OPW-1:0] ALU_SUB   = 5'b00001;
  localparam logic [ALU_OPW-1:0] ALU_AND   = 5'b00010;
  localparam logic [ALU_OPW-1:0] ALU_OR    = 5'b00011;
  localparam logic [ALU_OPW-1:0] ALU_XOR   = 5'b00100;
  localparam logic [ALU_OPW-1:0] ALU_SLL   = 5'b00101;
  localparam logic [ALU_OPW-1:0] ALU_SRL   = 5'b00110;
  localparam logic [ALU_OPW-1:0] ALU_SRA   = 5'b00111;
  localparam logic [ALU_OPW-1:0] ALU_SLT   = 5'b01000;
  localparam logic [ALU_OPW-1:0] ALU_SLTU  = 5'b01001;
  localparam logic [ALU_OPW-1:0] ALU_LUI   = 5'b01010;
  localparam logic [ALU_OPW-1:0] ALU_AUIPC = 5'b01011;

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_e;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between requesters, the consumer and the shared-ALU arbiter.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = 1
);
  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0]                 req_ready;
  logic [NREQ-1:0][XLEN-1:0]       req_src0;
  logic [NREQ-1:0][XLEN-1:0]       req_src1;
  logic [NREQ-1:0][ALU_OPW-1:0]    req_op;
  logic                            resp_valid;
  logic                            resp_ready;
  logic [XLEN-1:0]                 resp_data;
  logic [TAGW-1:0]                 resp_tag;

  modport master (
    output req_valid, req_src0, req_src1, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_src0, req_src1, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/alu_core.sv
// Combinational integer ALU; unknown opcodes produce zero.
module alu_core
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]    src0,
  input  logic [XLEN-1:0]    src1,
  input  logic [ALU_OPW-1:0] op,
  output logic [XLEN-1:0]    res
);
  logic [4:0] shamt;
  assign shamt = src1[4:0];

  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:   res = src0 + src1;
      ALU_SUB:   res = src0 - src1;
      ALU_AND:   res = src0 & src1;
      ALU_OR:    res = src0 | src1;
      ALU_XOR:   res = src0 ^ src1;
      ALU_SLL:   res = src0 << shamt;
      ALU_SRL:   res = src0 >> shamt;
      ALU_SRA:   res = $unsigned($signed(src0) >>> shamt);
      ALU_SLT:   res = {{(XLEN-1){1'b0}}, $signed(src0) < $signed(src1)};
      ALU_SLTU:  res = {{(XLEN-1){1'b0}}, src0 < src1};
      ALU_LUI:   res = src1;
      ALU_AUIPC: res = src0 + src1;
      default:   res = '0;
    endcase
  end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted req at or after ptr (wrapping), one-hot plus binary index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int TAGW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [TAGW-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [TAGW-1:0] idx
);
  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && !found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = TAGW'(j);
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// One shared ALU behind a round-robin arbiter with a single registered result slot.
// A drain and a new grant may land in the same cycle, so the slot streams at one op/cycle.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  alu_share_arbiter_if.slave  bus
);
  buf_state_e      state, state_nxt;
  logic [TAGW-1:0] ptr, ptr_nxt, gidx;
  logic [NREQ-1:0] gnt;
  logic            can_accept, hs;
  logic [XLEN-1:0] alu_res, data_q;
  logic [TAGW-1:0] tag_q;

  assign can_accept = (state == BUF_EMPTY) | bus.resp_ready;

  // rstn gates the grant so no requester sees ready while reset is held
  rr_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .en  (can_accept & rstn),
    .gnt (gnt),
    .idx (gidx)
  );

  assign bus.req_ready = gnt;
  assign hs            = |gnt;
  assign ptr_nxt       = (gidx == TAGW'(NREQ-1)) ? '0 : gidx + TAGW'(1);

  alu_core u_alu (
    .src0 (bus.req_src0[gidx]),
    .src1 (bus.req_src1[gidx]),
    .op   (bus.req_op[gidx]),
    .res  (alu_res)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= BUF_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BUF_EMPTY: if (hs) state_nxt = BUF_FULL;
      BUF_FULL:  if (bus.resp_ready && !hs) state_nxt = BUF_EMPTY;
      default:   state_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
      tag_q  <= '0;
      ptr    <= '0;
    end else if (hs) begin
      data_q <= alu_res;
      tag_q  <= gidx;
      ptr    <= ptr_nxt;
    end
  end

  assign bus.resp_valid = (state == BUF_FULL);
  assign bus.resp_data  = data_q;
  assign bus.resp_tag   = tag_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: stimulus pushes hand-computed results to a queue, a negedge monitor pops on resp handshakes.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [0:0]  tag;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  exp_t sb[$];

  alu_share_arbiter_if #(.NREQ(2), .TAGW(1)) bus ();

  alu_share_arbiter #(.NREQ(2), .TAGW(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstn && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", bus.resp_data, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", bus.resp_data, e.data);
        chk("resp_tag", {31'b0, bus.resp_tag}, {31'b0, e.tag});
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    bus.req_src0[i] = a;
    bus.req_src1[i] = b;
    bus.req_op[i]   = op;
  endtask

  task automatic issue_one(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [31:0] exp);
    int n;
    exp_t e;
    @(posedge clk); #1;
    set_req(i, a, b, op);
    bus.req_valid[i] = 1'b1;
    e.data = exp;
    e.tag  = 1'(i);
    sb.push_back(e);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ready[i]) break;
    end
    if (n == 20) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d, input int t);
    exp_t e;
    e.data = d;
    e.tag  = 1'(t);
    sb.push_back(e);
  endtask

  initial begin
    int n;
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    bus.req_valid  = '0;
    bus.req_src0   = '0;
    bus.req_src1   = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b1;

    // reset state, with requests pending
    #2;
    bus.req_valid = 2'b11;
    #1;
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_req_ready", {30'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    rstn = 1'b1;

    // single ops
    issue_one(0, 32'd5, 32'd7, ALU_ADD, 32'd12);
    issue_one(1, 32'h8000_0000, 32'd4, ALU_SRA, 32'hF800_0000);

    // contention: ptr is 0, grants alternate with no bubbles
    @(posedge clk); #1;
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    set_req(1, 32'd2, 32'd2, ALU_ADD);
    bus.req_valid = 2'b11;
    push_exp(32'd2, 0); push_exp(32'd4, 1); push_exp(32'd2, 0); push_exp(32'd4, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_grant", {30'b0, bus.req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) chk("no_bubble", {31'b0, bus.resp_valid}, 32'd1);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("no_bubble_last", {31'b0, bus.resp_valid}, 32'd1);

    // backpressure: SUB 3-5 held through a 3-cycle stall
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    set_req(0, 32'd3, 32'd5, ALU_SUB);
    bus.req_valid = 2'b01;
    push_exp(32'hFFFF_FFFE, 0);
    @(negedge clk);
    chk("bp_grant0", {30'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    set_req(1, 32'd10, 32'd20, ALU_ADD);
    bus.req_valid = 2'b10;
    push_exp(32'd30, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, bus.resp_valid}, 32'd1);
      chk("bp_data", bus.resp_data, 32'hFFFF_FFFE);
      chk("bp_ready0", {30'b0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_grant", {30'b0, bus.req_ready}, 32'd2);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("bp_after_valid", {31'b0, bus.resp_valid}, 32'd1);

    // ops sweep
    issue_one(0, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'd1);
    issue_one(1, 32'hFFFF_FFFF, 32'd1, ALU_SLTU, 32'd0);
    issue_one(0, 32'h0000_DEAD, 32'h1234_5000, ALU_LUI, 32'h1234_5000);
    issue_one(1, 32'd7, 32'd9, 5'b11111, 32'd0);
    issue_one(0, 32'hF0F0_00FF, 32'h0FF0_0F0F, ALU_XOR, 32'hFF00_0FF0);
    issue_one(1, 32'h0000_0001, 32'h0000_0024, ALU_SLL, 32'h0000_0010);
    issue_one(0, 32'h8000_0000, 32'd31, ALU_SRL, 32'h0000_0001);
    issue_one(1, 32'h0000_1000, 32'h0000_0234, ALU_AUIPC, 32'h0000_1234);

    // idle pointer: after grant 1 then 5 idle cycles, req0 wins
    issue_one(0, 32'd100, 32'd1, ALU_ADD, 32'd101);
    issue_one(1, 32'd200, 32'd2, ALU_ADD, 32'd202);
    repeat (5) @(posedge clk);
    #1;
    set_req(0, 32'hC, 32'hA, ALU_AND);
    set_req(1, 32'hC, 32'hA, ALU_OR);
    bus.req_valid = 2'b11;
    push_exp(32'h8, 0); push_exp(32'hE, 1);
    @(negedge clk);
    chk("idle_first", {30'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    @(negedge clk);
    chk("idle_second", {30'b0, bus.req_ready}, 32'd2);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;

    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("sb_drained", sb.size(), 32'd0);

    // async reset with a result pending: result discarded, no response
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    set_req(0, 32'd9, 32'd9, ALU_ADD);
    bus.req_valid = 2'b01;
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("mid_valid_pre", {31'b0, bus.resp_valid}, 32'd1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("mid_rst_data", bus.resp_data, 32'd0);
    chk("mid_rst_tag", {31'b0, bus.resp_tag}, 32'd0);
    bus.resp_ready = 1'b1;
    #1;
    chk("mid_rst_ready", {30'b0, bus.req_ready}, 32'd0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", {31'b0, bus.resp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
